binary_to_bcd_seq: RTL

Parametrised, multi-cycle binary-to-BCD converter using the shift-add-3 (double-dabble) method. It serves the clock display path and any other numeric readout, and replaces single-purpose combinational 2-digit converters for wider values. Results are delivered with a valid/ready handshake on both input and output. Any input wider than the configured digit count raises an overflow flag instead of producing silent garbage.

---
 rtl/binary_to_bcd_seq_if.sv | 46 ++++
 rtl/binary_to_bcd_seq.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/binary_to_bcd_seq_if.sv
// Bus bundle for binary_to_bcd_seq: request side (binary value in) and
// result side (BCD digits out), each with its own valid/ready pair.
//
// Handshake rule for both pairs: a transfer happens on a rising clock edge
// where valid and ready are both 1. The sender holds data and valid steady
// until that edge. The receiver may raise or lower ready freely. Data is
// only meaningful while valid is 1.
interface binary_to_bcd_seq_if #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
);

  // Request path: producer -> converter
  logic [WIDTH-1:0]    i_binary;
  logic                i_valid;
  logic                o_ready;

  // Result path: converter -> consumer
  logic [4*DIGITS-1:0] o_bcd;
  logic                o_overflow;
  logic                o_valid;
  logic                i_ready;

  // Converter side of the bundle
  modport slave (
    input  i_binary,
    input  i_valid,
    output o_ready,
    output o_bcd,
    output o_overflow,
    output o_valid,
    input  i_ready
  );

  // Producer/consumer side of the bundle
  modport master (
    output i_binary,
    output i_valid,
    input  o_ready,
    input  o_bcd,
    input  o_overflow,
    input  o_valid,
    output i_ready
  );

endinterface

// File: rtl/binary_to_bcd_seq.sv
// Multi-cycle binary-to-BCD converter using shift-add-3 (double dabble).
// It runs one bit per clock, so a WIDTH-bit value takes WIDTH SHIFT cycles.
// An input larger than the largest value that fits in DIGITS decimal digits
// gives all-F digits and the overflow flag.
// o_dbg_state exposes the FSM state (0=IDLE, 1=SHIFT, 2=DONE).
module binary_to_bcd_seq #(
  parameter int WIDTH  = 7,
  parameter int DIGITS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  binary_to_bcd_seq_if.slave   bus,
  output logic [1:0]           o_dbg_state
);

  // Largest value representable in DIGITS decimal digits (10^DIGITS - 1).
  function automatic integer pow10_minus1(input integer n);
    integer p;
    p = 1;
    for (integer j = 0; j < n; j++) begin
      p = p * 10;
    end
    return p - 1;
  endfunction

  localparam integer MAX_VAL = pow10_minus1(DIGITS);
  localparam int     SW      = 4 * DIGITS;
  localparam int     CW      = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_shift;     // binary bits still to be shifted in
  logic [SW-1:0]    r_scratch;   // BCD digits under construction
  logic [CW-1:0]    r_cnt;       // iterations remaining
  logic             r_ovf;       // captured input exceeded MAX_VAL
  logic [SW-1:0]    r_bcd;       // published result
  logic             r_overflow;  // published overflow flag

  logic             w_accept;
  logic             w_last;
  logic             w_in_ovf;
  logic [SW-1:0]    w_adj;
  logic [SW-1:0]    w_next_scratch;

  // Handshake qualifiers and the input range check.
  // The check is done in 33 bits so that WIDTH=32 still compares unsigned.
  always_comb begin
    w_accept = (r_state == S_IDLE) && bus.i_valid;
    w_last   = (r_state == S_SHIFT) && (r_cnt == CW'(1));
    w_in_ovf = 33'(bus.i_binary) > 33'(MAX_VAL);
  end

  // Add-3 correction: each digit >= 5 gets +3 (4-bit wrap, no carry out),
  // then the scratch shifts left one and takes the next binary MSB.
  // The bit shifted out of the top digit is dropped.
  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
    w_next_scratch = (w_adj << 1) | {{(SW-1){1'b0}}, r_shift[WIDTH-1]};
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_next_state = r_state;
    bus.o_ready  = 1'b0;
    bus.o_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.o_ready = 1'b1;
        if (bus.i_valid) begin
          w_next_state = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(1)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        bus.o_valid = 1'b1;
        if (bus.i_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Working registers: load on accept, iterate once per SHIFT cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_shift   <= bus.i_binary;
      r_scratch <= '0;
      r_cnt     <= CW'(WIDTH);
      r_ovf     <= w_in_ovf;
    end else if (r_state == S_SHIFT) begin
      r_shift   <= r_shift << 1;
      r_scratch <= w_next_scratch;
      r_cnt     <= r_cnt - CW'(1);
    end
  end

  // Result registers change only on the final iteration. They hold through
  // the next IDLE and SHIFT so that the consumer always sees the last answer.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_bcd      <= '0;
      r_overflow <= 1'b0;
    end else if (w_last) begin
      r_bcd      <= r_ovf ? {SW{1'b1}} : w_next_scratch;
      r_overflow <= r_ovf;
    end
  end

  // Drive the result bus and the debug state view.
  always_comb begin
    bus.o_bcd      = r_bcd;
    bus.o_overflow = r_overflow;
    o_dbg_state    = r_state;
  end

endmodule
